// File: rtl/lights_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lights_sequencer
//  Description : Control front-end for lights_selector. Debounces the raw
//                step and mode push-buttons, runs the WHITE / MANUAL / AUTO
//                mode machine and drives sel plus one-cycle step pulses into
//                the colour counter.
//  Ports       : clk         system clock, rising edge
//                rst         asynchronous reset, active-high
//                button_raw  raw step push-button (asynchronous, bouncy)
//                mode_raw    raw mode push-button (asynchronous, bouncy)
//                sel         0 = white, 1 = RGB colour (registered)
//                step        one-cycle advance pulse (registered)
//                state       00 WHITE, 01 MANUAL, 10 AUTO (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module lights_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DWELL_CYCLES    = 100,
    parameter int IDLE_TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_raw,
    input  logic       mode_raw,
    output logic       sel,
    output logic       step,
    output logic [1:0] state
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int c_DWELL_W = $clog2(DWELL_CYCLES);
    localparam int c_IDLE_W  = $clog2(IDLE_TIMEOUT);

    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST  = c_IDLE_W'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] c_ST_WHITE  = 2'b00;
    localparam logic [1:0] c_ST_MANUAL = 2'b01;
    localparam logic [1:0] c_ST_AUTO   = 2'b10;

    // index 0 = step button, index 1 = mode button
    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic       w_step_p;
    logic       w_mode_p;

    assign w_raw    = {mode_raw, button_raw};
    assign w_step_p = w_press[0];
    assign w_mode_p = w_press[1];

    // ------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and rising-edge press detector.
    // The stable level only changes after DEBOUNCE_CYCLES consecutive synced
    // samples disagree with it; any agreeing sample restarts the count.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic              r_sync1;
            logic              r_sync2;
            logic              r_stable;
            logic              r_stable_d;
            logic              r_press;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_press    <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                    r_stable_d <= r_stable;
                    // press registered so the FSM sees a clean single-cycle pulse
                    r_press    <= r_stable & ~r_stable_d;
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [c_IDLE_W-1:0]  r_idle;
    logic [c_DWELL_W-1:0] r_dwell;
    logic                 r_step;
    logic                 r_sel;

    logic [1:0]           w_state_next;
    logic [c_IDLE_W-1:0]  w_idle_next;
    logic [c_DWELL_W-1:0] w_dwell_next;
    logic                 w_step_next;
    logic                 w_sel_next;

    // state register (outputs are registered alongside the state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_WHITE;
            r_idle  <= '0;
            r_dwell <= '0;
            r_step  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idle  <= w_idle_next;
            r_dwell <= w_dwell_next;
            r_step  <= w_step_next;
            r_sel   <= w_sel_next;
        end
    end

    // next-state logic; counters default to 0 so they clear on every entry
    // and stay parked outside their own mode
    always_comb begin
        w_state_next = r_state;
        w_idle_next  = '0;
        w_dwell_next = '0;
        case (r_state)
            c_ST_WHITE: begin
                if (w_mode_p) w_state_next = c_ST_MANUAL;
            end
            c_ST_MANUAL: begin
                if (w_mode_p) begin
                    w_state_next = c_ST_AUTO;
                end else if (w_step_p) begin
                    w_idle_next = '0;
                end else if (r_idle == c_IDLE_LAST) begin
                    w_state_next = c_ST_WHITE;
                end else begin
                    w_idle_next = r_idle + c_IDLE_W'(1);
                end
            end
            c_ST_AUTO: begin
                if (w_mode_p) begin
                    w_state_next = c_ST_WHITE;
                end else if (r_dwell != c_DWELL_LAST) begin
                    w_dwell_next = r_dwell + c_DWELL_W'(1);
                end
            end
            default: w_state_next = c_ST_WHITE;
        endcase
    end

    // output logic; a mode press always suppresses the step pulse
    always_comb begin
        w_step_next = 1'b0;
        case (r_state)
            c_ST_MANUAL: w_step_next = w_step_p & ~w_mode_p;
            c_ST_AUTO:   w_step_next = ~w_mode_p & (r_dwell == c_DWELL_LAST);
            default:     w_step_next = 1'b0;
        endcase
        w_sel_next = (w_state_next != c_ST_WHITE);
    end

    assign state = r_state;
    assign sel   = r_sel;
    assign step  = r_step;

endmodule
`default_nettype wire
